// File: rtl/sdio_dev_cmd.sv
// Device-side SD command engine: receives and checks host command frames on CMD,
// then serialises the device's R48/R136 response and R48b busy on DAT0.
module sdio_dev_cmd #(
  parameter int NCR        = 2,
  parameter int RESP_TMOUT = 64
) (
  input  logic         sd_clk,
  input  logic         rstn,
  input  logic         sd_rst,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe,
  output logic         dat0_o,
  output logic         dat0_oe,
  output logic         cmd_valid,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_crc_err_event,
  output logic         cmd_end_err_event,
  input  logic         resp_start,
  input  logic [1:0]   resp_type,
  input  logic [5:0]   resp_index,
  input  logic [119:0] resp_data,
  input  logic         busy_i,
  output logic         resp_done,
  output logic         resp_tmout_event,
  output logic         dev_busy,
  output logic [3:0]   fsm_st
);

  localparam int WMAX = (NCR > RESP_TMOUT) ? NCR : RESP_TMOUT;
  localparam int WW   = $clog2(WMAX + 2);

  typedef enum logic [3:0] {
    IDLE, RX_TRANS, RX_INDEX, RX_ARG, RX_CRC, RX_END, RESP_WAIT,
    TX_START, TX_TRANS, TX_INDEX, TX_ARG, TX_CRC, TX_END, TX_BUSY
  } state_t;

  typedef enum logic [1:0] {
    RT_NONE = 2'b00,
    RT_R136 = 2'b01,
    RT_R48  = 2'b10,
    RT_R48B = 2'b11
  } resp_t;

  typedef enum logic [1:0] {BSY_ENTER, BSY_LOW, BSY_HIGH} busy_ph_t;

  typedef struct packed {
    state_t        st;
    busy_ph_t      ph;
    logic [6:0]    cnt;
    logic [WW-1:0] wcnt;
    logic [6:0]    crc;
    logic [6:0]    rx_crc;
    logic [5:0]    rx_idx;
    logic [31:0]   rx_arg;
    resp_t         tx_type;
    logic [5:0]    tx_idx;
    logic [119:0]  tx_data;
    logic          cmd_o;
    logic          cmd_oe;
    logic          dat0_o;
    logic          dat0_oe;
    logic          cmd_valid;
    logic [5:0]    cmd_index;
    logic [31:0]   cmd_arg;
    logic          crc_err;
    logic          end_err;
    logic          resp_done;
    logic          tmout;
    logic          dev_busy;
  } regs_t;

  function automatic regs_t regs_rst();
    regs_t r;
    r        = '0;
    r.st     = IDLE;
    r.cmd_o  = 1'b1;
    r.dat0_o = 1'b1;
    return r;
  endfunction

  // Serial CRC7, G(x) = x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  regs_t regs_q, regs_d;

  always_comb begin
    // NOTE: blocking assignments in combinational logic; every field starts from
    // its held value or a default, so no path leaves a latch behind.
    regs_d           = regs_q;
    regs_d.cmd_o     = 1'b1;
    regs_d.cmd_oe    = 1'b0;
    regs_d.dat0_o    = 1'b1;
    regs_d.dat0_oe   = 1'b0;
    regs_d.cmd_valid = 1'b0;
    regs_d.crc_err   = 1'b0;
    regs_d.end_err   = 1'b0;
    regs_d.resp_done = 1'b0;
    regs_d.tmout     = 1'b0;
    regs_d.dev_busy  = 1'b0;

    unique case (regs_q.st)
      IDLE: begin
        if (!cmd_i) begin
          regs_d.st  = RX_TRANS;
          regs_d.crc = '0;
        end
      end
      RX_TRANS: begin
        regs_d.crc = crc7_next(regs_q.crc, cmd_i);
        regs_d.cnt = 7'd5;
        regs_d.st  = cmd_i ? RX_INDEX : IDLE;
      end
      RX_INDEX: begin
        regs_d.crc    = crc7_next(regs_q.crc, cmd_i);
        regs_d.rx_idx = {regs_q.rx_idx[4:0], cmd_i};
        regs_d.cnt    = regs_q.cnt - 7'd1;
        if (regs_q.cnt == '0) begin
          regs_d.cnt = 7'd31;
          regs_d.st  = RX_ARG;
        end
      end
      RX_ARG: begin
        regs_d.crc    = crc7_next(regs_q.crc, cmd_i);
        regs_d.rx_arg = {regs_q.rx_arg[30:0], cmd_i};
        regs_d.cnt    = regs_q.cnt - 7'd1;
        if (regs_q.cnt == '0) begin
          regs_d.cnt = 7'd6;
          regs_d.st  = RX_CRC;
        end
      end
      RX_CRC: begin
        regs_d.rx_crc = {regs_q.rx_crc[5:0], cmd_i};
        regs_d.cnt    = regs_q.cnt - 7'd1;
        if (regs_q.cnt == '0) regs_d.st = RX_END;
      end
      RX_END: begin
        if (regs_q.rx_crc != regs_q.crc) begin
          regs_d.crc_err = 1'b1;
          regs_d.st      = IDLE;
        end else if (!cmd_i) begin
          regs_d.end_err = 1'b1;
          regs_d.st      = IDLE;
        end else begin
          regs_d.cmd_valid = 1'b1;
          regs_d.cmd_index = regs_q.rx_idx;
          regs_d.cmd_arg   = regs_q.rx_arg;
          regs_d.wcnt      = WW'(1);
          regs_d.st        = RESP_WAIT;
        end
      end
      RESP_WAIT: begin
        // wcnt holds the number of the edge being evaluated, counted from the end bit.
        regs_d.wcnt = regs_q.wcnt + WW'(1);
        if (!cmd_i) begin
          regs_d.st  = RX_TRANS;
          regs_d.crc = '0;
        end else if (resp_start) begin
          regs_d.tx_type = resp_t'(resp_type);
          regs_d.tx_idx  = (resp_t'(resp_type) == RT_R136) ? 6'h3F : resp_index;
          regs_d.tx_data = (resp_t'(resp_type) == RT_R136) ? resp_data
                                                           : {resp_data[31:0], 88'd0};
          if (resp_t'(resp_type) == RT_NONE) begin
            regs_d.resp_done = 1'b1;
            regs_d.st        = IDLE;
          end else begin
            regs_d.st = TX_START;
          end
        end else if (regs_q.wcnt == WW'(RESP_TMOUT)) begin
          regs_d.tmout = 1'b1;
          regs_d.st    = IDLE;
        end
      end
      TX_START: begin
        if (regs_q.wcnt >= WW'(NCR)) begin
          regs_d.cmd_o  = 1'b0;
          regs_d.cmd_oe = 1'b1;
          regs_d.crc    = '0;
          regs_d.st     = TX_TRANS;
        end else begin
          regs_d.wcnt = regs_q.wcnt + WW'(1);
        end
      end
      TX_TRANS: begin
        regs_d.cmd_o  = 1'b0;
        regs_d.cmd_oe = 1'b1;
        regs_d.cnt    = 7'd5;
        regs_d.st     = TX_INDEX;
      end
      TX_INDEX: begin
        regs_d.cmd_o  = regs_q.tx_idx[5];
        regs_d.cmd_oe = 1'b1;
        regs_d.tx_idx = {regs_q.tx_idx[4:0], 1'b0};
        // R136 CRC covers only the payload, so the header leaves it at zero.
        if (regs_q.tx_type != RT_R136) regs_d.crc = crc7_next(regs_q.crc, regs_q.tx_idx[5]);
        regs_d.cnt = regs_q.cnt - 7'd1;
        if (regs_q.cnt == '0) begin
          regs_d.cnt = (regs_q.tx_type == RT_R136) ? 7'd119 : 7'd31;
          regs_d.st  = TX_ARG;
        end
      end
      TX_ARG: begin
        regs_d.cmd_o   = regs_q.tx_data[119];
        regs_d.cmd_oe  = 1'b1;
        regs_d.tx_data = {regs_q.tx_data[118:0], 1'b0};
        regs_d.crc     = crc7_next(regs_q.crc, regs_q.tx_data[119]);
        regs_d.cnt     = regs_q.cnt - 7'd1;
        if (regs_q.cnt == '0) begin
          regs_d.cnt = 7'd6;
          regs_d.st  = TX_CRC;
        end
      end
      TX_CRC: begin
        regs_d.cmd_o  = regs_q.crc[6];
        regs_d.cmd_oe = 1'b1;
        regs_d.crc    = {regs_q.crc[5:0], 1'b0};
        regs_d.cnt    = regs_q.cnt - 7'd1;
        if (regs_q.cnt == '0) regs_d.st = TX_END;
      end
      TX_END: begin
        regs_d.cmd_o  = 1'b1;
        regs_d.cmd_oe = 1'b1;
        regs_d.ph     = BSY_ENTER;
        regs_d.st     = TX_BUSY;
      end
      TX_BUSY: begin
        unique case (regs_q.ph)
          BSY_ENTER: begin
            if (regs_q.tx_type == RT_R48B) begin
              regs_d.dat0_o  = 1'b0;
              regs_d.dat0_oe = 1'b1;
              regs_d.ph      = BSY_LOW;
            end else begin
              regs_d.resp_done = 1'b1;
              regs_d.st        = IDLE;
            end
          end
          BSY_LOW: begin
            regs_d.dat0_oe = 1'b1;
            if (busy_i) begin
              regs_d.dat0_o = 1'b0;
            end else begin
              regs_d.dat0_o    = 1'b1;
              regs_d.resp_done = 1'b1;
              regs_d.ph        = BSY_HIGH;
            end
          end
          default: regs_d.st = IDLE;
        endcase
      end
      default: regs_d.st = IDLE;
    endcase

    if (sd_rst) regs_d = regs_rst();
    regs_d.dev_busy = (regs_d.st != IDLE);
  end

  // NOTE: non-blocking assignments for state; every register, including the
  // response shadow, takes the same value on rstn and on sd_rst.
  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) regs_q <= regs_rst();
    else       regs_q <= regs_d;
  end

  assign cmd_o             = regs_q.cmd_o;
  assign cmd_oe            = regs_q.cmd_oe;
  assign dat0_o            = regs_q.dat0_o;
  assign dat0_oe           = regs_q.dat0_oe;
  assign cmd_valid         = regs_q.cmd_valid;
  assign cmd_index_o       = regs_q.cmd_index;
  assign cmd_arg_o         = regs_q.cmd_arg;
  assign cmd_crc_err_event = regs_q.crc_err;
  assign cmd_end_err_event = regs_q.end_err;
  assign resp_done         = regs_q.resp_done;
  assign resp_tmout_event  = regs_q.tmout;
  assign dev_busy          = regs_q.dev_busy;
  assign fsm_st            = regs_q.st;

endmodule

// File: tb/tb_sdio_dev_cmd.sv
// Directed bench for sdio_dev_cmd: host frames in, response frames and DAT0 busy
// checked against hand-derived timing and an independent CRC7 division model.
module tb_sdio_dev_cmd;

  logic         sd_clk = 1'b0;
  logic         rstn = 1'b0;
  logic         sd_rst = 1'b0;
  logic         cmd_i = 1'b1;
  logic         cmd_o, cmd_oe, dat0_o, dat0_oe;
  logic         cmd_valid;
  logic [5:0]   cmd_index_o;
  logic [31:0]  cmd_arg_o;
  logic         cmd_crc_err_event, cmd_end_err_event;
  logic         resp_start = 1'b0;
  logic [1:0]   resp_type = 2'b00;
  logic [5:0]   resp_index = '0;
  logic [119:0] resp_data = '0;
  logic         busy_i = 1'b0;
  logic         resp_done, resp_tmout_event, dev_busy;
  logic [3:0]   fsm_st;

  sdio_dev_cmd dut (
    .sd_clk(sd_clk), .rstn(rstn), .sd_rst(sd_rst), .cmd_i(cmd_i),
    .cmd_o(cmd_o), .cmd_oe(cmd_oe), .dat0_o(dat0_o), .dat0_oe(dat0_oe),
    .cmd_valid(cmd_valid), .cmd_index_o(cmd_index_o), .cmd_arg_o(cmd_arg_o),
    .cmd_crc_err_event(cmd_crc_err_event), .cmd_end_err_event(cmd_end_err_event),
    .resp_start(resp_start), .resp_type(resp_type), .resp_index(resp_index),
    .resp_data(resp_data), .busy_i(busy_i), .resp_done(resp_done),
    .resp_tmout_event(resp_tmout_event), .dev_busy(dev_busy), .fsm_st(fsm_st)
  );

  always #5 sd_clk = ~sd_clk;

  localparam logic [47:0] CMD0     = 48'h40_0000_0000_95;
  localparam logic [47:0] CMD0_BAD = 48'h40_0000_0000_97;
  localparam logic [47:0] CMD0_END = 48'h40_0000_0000_94;
  localparam logic [47:0] CMD8     = 48'h48_0000_01AA_87;
  localparam logic [47:0] CMD2     = 48'h42_0000_0000_4D;
  localparam logic [119:0] R2_DATA = 120'h0123456789ABCDEF0123456789ABEF;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse totals, sampled once per cycle on the falling edge.
  int p_valid = 0, p_crc = 0, p_end = 0, p_done = 0, p_tmout = 0;
  int s_valid, s_crc, s_end, s_done, s_tmout;

  // Per-window observations.
  int k_first_oe, n_oe_w, k_done, k_tmout, n_dat_lo, n_dat_hi;
  logic [135:0] rx_bits;

  logic [39:0]  r48_msg;
  logic [47:0]  r48_exp;
  logic [135:0] r136_exp;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 as polynomial long division of msg * x^7 by 0x89.
  function automatic logic [6:0] crc7_model(input logic [119:0] msg, input int nbits);
    logic [7:0] rem;
    logic       b;
    rem = '0;
    for (int i = nbits - 1; i >= -7; i--) begin
      b = 1'b0;
      if (i >= 0) b = msg[i];
      rem = {rem[6:0], b};
      if (rem[7]) rem = rem ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  task automatic tick();
    @(negedge sd_clk);
    if (cmd_valid)         p_valid++;
    if (cmd_crc_err_event) p_crc++;
    if (cmd_end_err_event) p_end++;
    if (resp_done)         p_done++;
    if (resp_tmout_event)  p_tmout++;
  endtask

  task automatic snap();
    s_valid = p_valid; s_crc = p_crc; s_end = p_end; s_done = p_done; s_tmout = p_tmout;
  endtask

  // Returns just after the posedge that samples the end bit (edge 0).
  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      cmd_i = f[i];
      tick();
    end
    cmd_i = 1'b1;
  endtask

  // Observes edges k0 .. k0+ncyc-1; drops resp_start after the first edge and
  // releases busy_i busy_hold cycles after cmd_oe falls.
  task automatic watch(input int k0, input int ncyc, input int busy_hold);
    int k_rel;
    k_rel = -1;
    k_first_oe = -1; n_oe_w = 0; k_done = -1; k_tmout = -1;
    n_dat_lo = 0; n_dat_hi = 0; rx_bits = '0;
    for (int k = k0; k < k0 + ncyc; k++) begin
      tick();
      resp_start = 1'b0;
      if (cmd_oe) begin
        if (k_first_oe < 0) k_first_oe = k;
        n_oe_w++;
        rx_bits = {rx_bits[134:0], cmd_o};
      end else if (n_oe_w > 0 && k_rel < 0) begin
        k_rel = k;
      end
      if (resp_done)        k_done = k;
      if (resp_tmout_event) k_tmout = k;
      if (dat0_oe) begin
        if (dat0_o) n_dat_hi++;
        else        n_dat_lo++;
      end
      if (k_rel >= 0 && k == k_rel + busy_hold) busy_i = 1'b0;
    end
  endtask

  task automatic request(input logic [1:0] t, input logic [5:0] idx, input logic [119:0] d);
    resp_type  = t;
    resp_index = idx;
    resp_data  = d;
    resp_start = 1'b1;
  endtask

  initial begin
    // Reset state.
    tick(); tick();
    check("rst_cmd_o",   cmd_o, 1'b1);
    check("rst_cmd_oe",  cmd_oe, 1'b0);
    check("rst_dat0",    {dat0_oe, dat0_o}, 2'b01);
    check("rst_idx_arg", {cmd_index_o, cmd_arg_o}, 38'd0);
    check("rst_pulses",  {cmd_valid, cmd_crc_err_event, cmd_end_err_event, resp_done,
                          resp_tmout_event, dev_busy}, 6'd0);
    check("rst_fsm",     fsm_st, 4'd0);
    rstn = 1'b1;
    tick();

    // CMD0, response type none.
    snap();
    send_frame(CMD0);
    check("cmd0_valid", cmd_valid, 1'b1);
    check("cmd0_idx",   cmd_index_o, 6'd0);
    check("cmd0_arg",   cmd_arg_o, 32'd0);
    check("cmd0_wait",  fsm_st, 4'd6);
    request(2'b00, 6'd0, '0);
    watch(1, 4, 0);
    check("cmd0_done_edge", k_done, 1);
    check("cmd0_no_oe",     n_oe_w, 0);
    check("cmd0_idle",      fsm_st, 4'd0);
    check("cmd0_valid_cnt", p_valid - s_valid, 1);

    // CMD8, R48 requested in the cmd_valid cycle.
    r48_msg = {2'b00, 6'd8, 32'h0000_01AA};
    r48_exp = {r48_msg, crc7_model({80'd0, r48_msg}, 40), 1'b1};
    snap();
    send_frame(CMD8);
    check("cmd8_valid", cmd_valid, 1'b1);
    check("cmd8_idx",   cmd_index_o, 6'd8);
    check("cmd8_arg",   cmd_arg_o, 32'h0000_01AA);
    request(2'b10, 6'd8, 120'h1AA);
    watch(1, 60, 0);
    check("r48_start_edge", k_first_oe, 2);
    check("r48_oe_cycles",  n_oe_w, 48);
    check("r48_frame",      rx_bits, {88'd0, r48_exp});
    check("r48_done_edge",  k_done, 50);
    check("r48_done_cnt",   p_done - s_done, 1);
    check("r48_idle",       {dev_busy, fsm_st}, 5'd0);
    check("r48_idx_hold",   cmd_index_o, 6'd8);

    // CRC error, then end-bit error.
    snap();
    send_frame(CMD0_BAD);
    watch(1, 4, 0);
    check("crc_err_cnt",   p_crc - s_crc, 1);
    check("crc_no_valid",  (p_valid - s_valid) + (p_end - s_end), 0);
    check("crc_no_oe",     n_oe_w, 0);
    check("crc_idx_hold",  cmd_index_o, 6'd8);
    snap();
    send_frame(CMD0_END);
    watch(1, 4, 0);
    check("end_err_cnt",   p_end - s_end, 1);
    check("end_no_other",  (p_valid - s_valid) + (p_crc - s_crc), 0);
    check("end_idle",      fsm_st, 4'd0);

    // CMD2, R136 requested at edge 3.
    r136_exp = {2'b00, 6'h3F, R2_DATA, crc7_model(R2_DATA, 120), 1'b1};
    snap();
    send_frame(CMD2);
    check("cmd2_idx", cmd_index_o, 6'd2);
    tick(); tick();
    request(2'b01, 6'd2, R2_DATA);
    watch(3, 150, 0);
    check("r136_start_edge", k_first_oe, 4);
    check("r136_oe_cycles",  n_oe_w, 136);
    check("r136_frame",      rx_bits, r136_exp);
    check("r136_done_edge",  k_done, 140);
    check("r136_done_cnt",   p_done - s_done, 1);

    // R48b with busy held 10 cycles after the end bit.
    snap();
    send_frame(CMD8);
    busy_i = 1'b1;
    request(2'b11, 6'd8, 120'h1AA);
    watch(1, 80, 10);
    check("r48b_start_edge", k_first_oe, 2);
    check("r48b_oe_cycles",  n_oe_w, 48);
    check("r48b_frame",      rx_bits, {88'd0, r48_exp});
    check("r48b_dat_low",    n_dat_lo, 11);
    check("r48b_dat_high",   n_dat_hi, 1);
    check("r48b_done_edge",  k_done, 61);
    check("r48b_done_cnt",   p_done - s_done, 1);
    check("r48b_released",   {dat0_oe, fsm_st}, 5'd0);

    // No response: timeout at edge 64.
    snap();
    send_frame(CMD0);
    watch(1, 70, 0);
    check("tmout_edge", k_tmout, 64);
    check("tmout_cnt",  p_tmout - s_tmout, 1);
    check("tmout_idle", {n_oe_w[0], fsm_st}, 5'd0);

    // Soft reset in the middle of TX_ARG.
    send_frame(CMD8);
    request(2'b10, 6'd8, 120'h1AA);
    tick();
    resp_start = 1'b0;
    for (int i = 0; i < 60 && fsm_st != 4'd10; i++) tick();
    check("srst_in_txarg", {cmd_oe, fsm_st}, {1'b1, 4'd10});
    snap();
    sd_rst = 1'b1;
    tick();
    sd_rst = 1'b0;
    check("srst_oe_drop", {cmd_oe, dat0_oe}, 2'b00);
    check("srst_state",   {dev_busy, fsm_st}, 5'd0);
    watch(1, 6, 0);
    check("srst_no_pulse", (p_done - s_done) + (p_tmout - s_tmout) + n_oe_w, 0);
    send_frame(CMD0);
    check("srst_cmd0_valid", p_valid - s_valid, 1);
    check("srst_cmd0_fields", {cmd_index_o, cmd_arg_o, fsm_st}, {38'd0, 4'd6});
    request(2'b00, 6'd0, '0);
    watch(1, 3, 0);

    // Start + zero transmission bit is another device's response: ignored.
    snap();
    cmd_i = 1'b0; tick();
    cmd_i = 1'b0; tick();
    cmd_i = 1'b1; tick(); tick();
    check("foreign_idle",   fsm_st, 4'd0);
    check("foreign_silent", (p_valid - s_valid) + (p_crc - s_crc) + (p_end - s_end), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
